// File: rtl/bht_update_scheduler.sv
// Buffers up to two committed branch outcomes per cycle in an in-order FIFO and
// drains them one per cycle to the predictor's single BHT update port.
module bht_update_scheduler #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       commit0_valid,
  input  logic                       commit0_hit,
  input  logic [ADDR_W-1:0]          commit0_pc,
  input  logic                       commit1_valid,
  input  logic                       commit1_hit,
  input  logic [ADDR_W-1:0]          commit1_pc,
  output logic                       in_ready,
  input  logic                       upd_stall,
  output logic                       ena_to_pred,
  output logic                       hit_to_pred,
  output logic [ADDR_W-1:0]          pc_to_pred,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow_err,
  output logic [CNT_W-1:0]           stat_branches,
  output logic [CNT_W-1:0]           stat_hits
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PTR_W:0]   cnt_t;

  logic [ADDR_W-1:0] mem_pc  [DEPTH];
  logic              mem_hit [DEPTH];

  ptr_t wr_ptr, rd_ptr, wr_ptr_p1;
  cnt_t count;

  logic       any_valid, accept, deq;
  logic [1:0] n_enq, n_hit;
  logic [ADDR_W-1:0] single_pc;
  logic              single_hit;

  // At least two free slots guarantees an enqueue never lands on the head entry.
  assign in_ready   = (count <= cnt_t'(DEPTH - 2));
  assign fifo_count = count;

  assign any_valid = commit0_valid | commit1_valid;
  assign accept    = any_valid & in_ready;
  assign deq       = (count != '0) & ~upd_stall;
  assign wr_ptr_p1 = wr_ptr + ptr_t'(1);

  always_comb begin
    n_enq      = 2'd0;
    n_hit      = 2'd0;
    single_pc  = commit0_valid ? commit0_pc  : commit1_pc;
    single_hit = commit0_valid ? commit0_hit : commit1_hit;
    if (accept) begin
      n_enq = {1'b0, commit0_valid} + {1'b0, commit1_valid};
      n_hit = {1'b0, commit0_valid & commit0_hit} + {1'b0, commit1_valid & commit1_hit};
    end
  end

  // Storage is not reset; only the pointers and count define which slots are live.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (commit0_valid && commit1_valid) begin
        mem_pc[wr_ptr]     <= commit0_pc;
        mem_hit[wr_ptr]    <= commit0_hit;
        mem_pc[wr_ptr_p1]  <= commit1_pc;
        mem_hit[wr_ptr_p1] <= commit1_hit;
      end else begin
        mem_pc[wr_ptr]     <= single_pc;
        mem_hit[wr_ptr]    <= single_hit;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      ena_to_pred   <= 1'b0;
      hit_to_pred   <= 1'b0;
      pc_to_pred    <= '0;
      overflow_err  <= 1'b0;
      stat_branches <= '0;
      stat_hits     <= '0;
    end else begin
      wr_ptr        <= wr_ptr + ptr_t'(n_enq);
      count         <= count + cnt_t'(n_enq) - cnt_t'(deq);
      stat_branches <= stat_branches + CNT_W'(n_enq);
      stat_hits     <= stat_hits + CNT_W'(n_hit);
      ena_to_pred   <= deq;
      if (deq) begin
        rd_ptr      <= rd_ptr + ptr_t'(1);
        hit_to_pred <= mem_hit[rd_ptr];
        pc_to_pred  <= mem_pc[rd_ptr];
      end
      if (any_valid && !in_ready) begin
        overflow_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bht_update_scheduler.sv
// Directed bench for bht_update_scheduler: expected updates go into a queue at
// commit time and a negedge monitor pops and compares every predictor strobe.
module tb_bht_update_scheduler;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              commit0_valid, commit0_hit, commit1_valid, commit1_hit;
  logic [ADDR_W-1:0] commit0_pc, commit1_pc;
  logic              in_ready, upd_stall;
  logic              ena_to_pred, hit_to_pred;
  logic [ADDR_W-1:0] pc_to_pred;
  logic [$clog2(DEPTH):0] fifo_count;
  logic              overflow_err;
  logic [CNT_W-1:0]  stat_branches, stat_hits;

  int compared   = 0;
  int mismatched = 0;
  int mdl_cnt    = 0;
  logic [ADDR_W:0] exp_q[$];

  bht_update_scheduler #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .commit0_valid(commit0_valid), .commit0_hit(commit0_hit), .commit0_pc(commit0_pc),
    .commit1_valid(commit1_valid), .commit1_hit(commit1_hit), .commit1_pc(commit1_pc),
    .in_ready(in_ready), .upd_stall(upd_stall),
    .ena_to_pred(ena_to_pred), .hit_to_pred(hit_to_pred), .pc_to_pred(pc_to_pred),
    .fifo_count(fifo_count), .overflow_err(overflow_err),
    .stat_branches(stat_branches), .stat_hits(stat_hits)
  );

  always #5 clk = ~clk;

  // Every strobe must match the oldest outstanding commit.
  always @(negedge clk) begin
    if (rst && ena_to_pred) begin
      logic [ADDR_W:0] exp_e;
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL unexpected_strobe: got pc=0x%0h hit=%0b, required no strobe",
                 pc_to_pred, hit_to_pred);
      end else begin
        exp_e = exp_q.pop_front();
        if ({hit_to_pred, pc_to_pred} !== exp_e) begin
          mismatched++;
          $display("[TB] FAIL update_order: got pc=0x%0h hit=%0b, required pc=0x%0h hit=%0b",
                   pc_to_pred, hit_to_pred, exp_e[ADDR_W-1:0], exp_e[ADDR_W]);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  // Drives one cycle of commits from a negedge and returns at the following negedge.
  task automatic applyStimulus(input logic v0, input logic h0, input logic [ADDR_W-1:0] p0,
                               input logic v1, input logic h1, input logic [ADDR_W-1:0] p1,
                               input logic stall);
    bit accept, deq;
    int n;
    commit0_valid = v0; commit0_hit = h0; commit0_pc = p0;
    commit1_valid = v1; commit1_hit = h1; commit1_pc = p1;
    upd_stall     = stall;
    accept = (mdl_cnt <= DEPTH - 2) && (v0 || v1);
    n = 0;
    if (accept) begin
      if (v0) begin exp_q.push_back({h0, p0}); n++; end
      if (v1) begin exp_q.push_back({h1, p1}); n++; end
    end
    deq = (mdl_cnt != 0) && !stall;
    @(posedge clk);
    mdl_cnt = mdl_cnt + n - int'(deq);
    @(negedge clk);
    commit0_valid = 1'b0;
    commit1_valid = 1'b0;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(0, 0, '0, 0, 0, '0, 0);
  endtask

  initial begin
    rst = 1'b0; upd_stall = 1'b0;
    commit0_valid = 0; commit0_hit = 0; commit0_pc = '0;
    commit1_valid = 0; commit1_hit = 0; commit1_pc = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ena", 64'(ena_to_pred), 64'd0);
    checkOutput("reset_count", 64'(fifo_count), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_overflow", 64'(overflow_err), 64'd0);
    checkOutput("reset_branches", 64'(stat_branches), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Single lane-0 commit: strobe two cycles later, for exactly one cycle.
    applyStimulus(1, 1, 32'h100, 0, 0, '0, 0);
    checkOutput("t1_no_bypass", 64'(ena_to_pred), 64'd0);
    checkOutput("t1_count", 64'(fifo_count), 64'd1);
    idle(1);
    checkOutput("t1_ena", 64'(ena_to_pred), 64'd1);
    checkOutput("t1_pc", 64'(pc_to_pred), 64'h100);
    idle(1);
    checkOutput("t1_ena_once", 64'(ena_to_pred), 64'd0);
    checkOutput("t1_hold_pc", 64'(pc_to_pred), 64'h100);
    checkOutput("t1_branches", 64'(stat_branches), 64'd1);
    checkOutput("t1_hits", 64'(stat_hits), 64'd1);

    // Dual commits with continuous drain.
    applyStimulus(1, 1, 32'h0,  1, 0, 32'h4,  0);
    applyStimulus(1, 1, 32'h8,  1, 0, 32'hC,  0);
    applyStimulus(1, 0, 32'h10, 1, 1, 32'h14, 0);
    checkOutput("t2_count", 64'(fifo_count), 64'd4);
    checkOutput("t2_in_ready", 64'(in_ready), 64'd1);
    idle(8);
    checkOutput("t2_drained", 64'(exp_q.size()), 64'd0);
    checkOutput("t2_branches", 64'(stat_branches), 64'd7);
    checkOutput("t2_hits", 64'(stat_hits), 64'd4);

    // Stalled fill to full, then an overflow attempt.
    applyStimulus(1, 1, 32'h200, 1, 0, 32'h204, 1);
    applyStimulus(1, 1, 32'h208, 1, 0, 32'h20C, 1);
    applyStimulus(1, 1, 32'h210, 1, 0, 32'h214, 1);
    checkOutput("t3_count6", 64'(fifo_count), 64'd6);
    checkOutput("t3_ready_at6", 64'(in_ready), 64'd1);
    applyStimulus(1, 1, 32'h218, 1, 0, 32'h21C, 1);
    checkOutput("t3_count8", 64'(fifo_count), 64'd8);
    checkOutput("t3_not_ready", 64'(in_ready), 64'd0);
    checkOutput("t3_no_overflow_yet", 64'(overflow_err), 64'd0);
    applyStimulus(1, 1, 32'hBAD0, 1, 1, 32'hBAD4, 1);
    checkOutput("t3_overflow", 64'(overflow_err), 64'd1);
    checkOutput("t3_count_held", 64'(fifo_count), 64'd8);
    checkOutput("t3_branches", 64'(stat_branches), 64'd15);
    checkOutput("t3_hits", 64'(stat_hits), 64'd8);
    idle(10);
    checkOutput("t3_drained", 64'(exp_q.size()), 64'd0);
    checkOutput("t3_count0", 64'(fifo_count), 64'd0);
    checkOutput("t3_overflow_sticky", 64'(overflow_err), 64'd1);

    // Lane 1 alone, then lane 0 alone.
    applyStimulus(0, 0, '0, 1, 0, 32'h40, 0);
    applyStimulus(1, 0, 32'h44, 0, 0, '0, 0);
    idle(4);
    checkOutput("t4_drained", 64'(exp_q.size()), 64'd0);
    checkOutput("t4_branches", 64'(stat_branches), 64'd17);
    checkOutput("t4_hits", 64'(stat_hits), 64'd8);

    // Asynchronous reset while draining discards everything.
    applyStimulus(1, 1, 32'h300, 1, 0, 32'h304, 1);
    applyStimulus(1, 0, 32'h308, 1, 1, 32'h30C, 1);
    applyStimulus(1, 1, 32'h310, 0, 0, '0, 1);
    checkOutput("t5_count5", 64'(fifo_count), 64'd5);
    idle(1);
    checkOutput("t5_draining", 64'(ena_to_pred), 64'd1);
    #2 rst = 1'b0;
    #1;
    checkOutput("t5_async_ena", 64'(ena_to_pred), 64'd0);
    checkOutput("t5_async_count", 64'(fifo_count), 64'd0);
    checkOutput("t5_async_overflow", 64'(overflow_err), 64'd0);
    checkOutput("t5_async_branches", 64'(stat_branches), 64'd0);
    exp_q.delete();
    mdl_cnt = 0;
    @(negedge clk);
    rst = 1'b1;
    idle(1);
    checkOutput("t5_first_after_release", 64'(ena_to_pred), 64'd0);
    idle(4);
    checkOutput("t5_quiet_count", 64'(fifo_count), 64'd0);

    // 3*DEPTH single commits with continuous drain wrap the pointers three times.
    for (int i = 0; i < 3 * DEPTH; i++)
      applyStimulus(1, (i % 3) == 0, 32'h1000 + 32'(4 * i), 0, 0, '0, 0);
    idle(4);
    checkOutput("t6_drained", 64'(exp_q.size()), 64'd0);
    checkOutput("t6_branches", 64'(stat_branches), 64'd24);
    checkOutput("t6_hits", 64'(stat_hits), 64'd8);
    checkOutput("t6_count0", 64'(fifo_count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded time limit, required completion");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/bht_update_scheduler.md
Name: bht_update_scheduler

Overview:
- Sits between the ROB commit stage and the branch predictor's single BHT update port (ena/hit/pc).
- The ROB can retire up to two branches per cycle. The predictor accepts one update per cycle.
- This block buffers committed branch outcomes in a small in-order FIFO and drains them one per cycle to the predictor.
- It applies backpressure to the ROB, honours a drain stall, and keeps branch/hit statistics.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 4.
- ADDR_W, 32, PC width; matches the ADDR_TYPE width.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-low (0 = reset).
- commit0_valid  in  1  lane 0 retires a conditional branch this cycle (older lane).
- commit0_hit  in  1  lane 0 branch was actually taken.
- commit0_pc  in  ADDR_W  lane 0 branch PC.
- commit1_valid  in  1  lane 1 retires a branch (younger than lane 0).
- commit1_hit  in  1  lane 1 taken.
- commit1_pc  in  ADDR_W  lane 1 PC.
- in_ready  out  1  FIFO has >= 2 free slots; ROB may present commits.
- upd_stall  in  1  hold draining this cycle.
- ena_to_pred  out  1  registered one-cycle update strobe to the predictor.
- hit_to_pred  out  1  registered taken flag, valid with the strobe.
- pc_to_pred  out  ADDR_W  registered PC, valid with the strobe.
- fifo_count  out  clog2(DEPTH)+1  current occupancy.
- overflow_err  out  1  sticky: a commit arrived while in_ready was 0.
- stat_branches  out  CNT_W  total branches enqueued.
- stat_hits  out  CNT_W  total enqueued branches with hit=1.

Behaviour:
- Reset (rst=0, asynchronous):
  - wr_ptr, rd_ptr and count go to 0.
  - ena_to_pred, hit_to_pred, pc_to_pred go to 0.
  - overflow_err goes to 0; both stat counters go to 0.
  - FIFO storage contents are don't-care.
- A reset asserted mid-drain discards all pending entries. The first cycle after release shows ena_to_pred=0.
- in_ready = (count <= DEPTH-2). It is combinational from the registered count and does not depend on this cycle's dequeue.
- Enqueue (only when in_ready=1):
  - Both lanes valid: lane 0 is written to wr_ptr, lane 1 to wr_ptr+1; wr_ptr advances by 2.
  - Only one lane valid (either lane): that entry is written to wr_ptr; wr_ptr advances by 1.
  - Pointers wrap modulo DEPTH.
- Overflow: any commitX_valid with in_ready=0 drops that entire cycle's commits, sets overflow_err, and leaves the stats unchanged. overflow_err clears only on reset.
- Dequeue: when count != 0 and upd_stall=0, the head entry is popped.
  - On the next edge, ena_to_pred=1 and hit/pc carry that entry.
  - Otherwise ena_to_pred=0 on the next edge, and hit/pc hold their previous values.
- Latency: an entry enqueued at edge N can be popped at edge N+1 at the earliest and appears on the outputs after edge N+2. There is no bypass from the commit inputs to the outputs.
- Count and simultaneous events: count_next = count + n_enq - deq. Enqueue and dequeue in the same cycle are allowed. count never exceeds DEPTH.
- Order: output order strictly equals commit order, with lane 0 before lane 1 within a cycle.
- Statistics:
  - stat_branches increments by n_enq (0/1/2) on accepted cycles.
  - stat_hits increments by the number of accepted lanes with hit=1.
  - Both counters wrap modulo 2^CNT_W.
- upd_stall held high: the FIFO can fill. in_ready falls once count > DEPTH-2 and enqueues then stop.

Test Plan:
- Reset, then lane 0 only with pc=0x100, hit=1 at cycle 1 -> ena_to_pred=1, pc_to_pred=0x100, hit_to_pred=1 in cycle 3 only; stat_branches=1, stat_hits=1.
- Both lanes each cycle for 3 cycles (pcs 0x0,0x4 / 0x8,0xC / 0x10,0x14), upd_stall=0 -> six strobes in pc order 0x0..0x14 on consecutive cycles; in_ready drops when count>6 and no entry is lost.
- upd_stall=1, dual commits until in_ready=0 -> count reaches 8 (or 7 with a single-lane commit); a further commit sets overflow_err, count and stats unchanged; releasing the stall drains all entries in order.
- Lane 1 only (pc=0x40, hit=0) interleaved with lane 0 only (pc=0x44) -> outputs 0x40 then 0x44; stat_hits unchanged.
- Fill with 5 entries, pull rst low asynchronously between edges -> ena_to_pred and fifo_count go to 0 immediately; after release with no commits there are no strobes.
- Stream 3*DEPTH single commits with continuous drain -> pointers wrap correctly, output order is preserved, stat_branches=24.
